pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage issue request and hazard-control response bundle.
// master drives the ID instruction fields; slave returns issue/stall/bubble and status.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [4:0]       id_rd;
    logic             id_wr;
    logic             id_halt;
    logic             issue;
    logic             stall;
    logic             bubble;
    logic             halted;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr, id_halt,
        input  issue, stall, bubble, halted, state, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr, id_halt,
        output issue, stall, bubble, halted, state, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline RAW hazard interlock with HLT drain; issue/stall/bubble are zero-cycle combinational.
// Backpressure: a hazard holds the ID instruction (stall) and injects a bubble into EX until the producer retires.
module pipe_hazard_ctrl #(
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input  logic              clk1,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [DEPTH-1:0] slot_vld;
    logic [4:0]       slot_rd [DEPTH];
    logic [CNT_W-1:0] stall_cnt_q;
    logic             hit_rs;
    logic             hit_rt;
    logic             hazard;
    logic             upstream_empty;
    logic             slot_load;
    logic             issue_c;
    logic             stall_c;

    // WB slot is still compared: its write lands at the end of this cycle,
    // so a reader only becomes safe once the destination has left the scoreboard.
    always_comb begin
        hit_rs         = 1'b0;
        hit_rt         = 1'b0;
        upstream_empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld[i] && (slot_rd[i] == hz.id_rs)) hit_rs = 1'b1;
            if (slot_vld[i] && (slot_rd[i] == hz.id_rt)) hit_rt = 1'b1;
            if ((i < DEPTH - 1) && slot_vld[i]) upstream_empty = 1'b0;
        end
        hit_rs = hit_rs & hz.id_use_rs & (hz.id_rs != 5'd0);
        hit_rt = hit_rt & hz.id_use_rt & (hz.id_rt != 5'd0);
        hazard = rst_n & (hit_rs | hit_rt);
    end

    always_comb begin
        state_d = state_q;
        issue_c = 1'b0;
        stall_c = 1'b0;
        if (!rst_n) begin
            issue_c = hz.id_valid;
        end else begin
            case (state_q)
                ST_RUN: begin
                    issue_c = hz.id_valid & ~hazard;
                    stall_c = hz.id_valid & hazard;
                    if (issue_c && hz.id_halt) state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    stall_c = 1'b1;
                    // Only the WB slot may still be valid: it empties at this edge.
                    if (upstream_empty) state_d = ST_HALTED;
                end
                ST_HALTED: begin
                    stall_c = 1'b1;
                end
                default: begin
                    stall_c = 1'b1;
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    assign slot_load    = issue_c & hz.id_wr & (hz.id_rd != 5'd0);
    assign hz.issue     = issue_c;
    assign hz.stall     = stall_c;
    assign hz.bubble    = ~issue_c;
    assign hz.state     = rst_n ? state_q : ST_RUN;
    assign hz.halted    = rst_n & (state_q == ST_HALTED);
    assign hz.stall_cnt = stall_cnt_q;

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            slot_vld    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            slot_vld[0] <= slot_load;
            for (int i = 1; i < DEPTH; i++) slot_vld[i] <= slot_vld[i-1];
            if ((state_q == ST_RUN) && stall_c && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk1) begin
        slot_rd[0] <= hz.id_rd;
        for (int i = 1; i < DEPTH; i++) slot_rd[i] <= slot_rd[i-1];
    end
endmodule
